// File: rtl/arbitro_memoria_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package arbitro_memoria_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CORE  = 1'b0;
  localparam logic PORT_LOAD  = 1'b1;
  localparam int   DATA_W_DEF = 32;
  localparam int   ADDR_W_DEF = 5;

endpackage

// File: rtl/arbitro_rr.sv
// Two-input picker with last-granted pointer. Round-robin by default;
// ARBITRO_PRIO_CORE_EN makes port 0 win every tie.
module arbitro_rr
  import arbitro_memoria_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       win
);

  logic last;

  always_ff @(posedge clk) begin
    if (!rst)     last <= PORT_LOAD;
    else if (upd) last <= upd_idx;
  end

  always_comb begin
    win = PORT_CORE;
    if (req == 2'b11) begin
`ifdef ARBITRO_PRIO_CORE_EN
      win = PORT_CORE;
`else
      win = ~last;
`endif
    end else if (req[1]) begin
      win = PORT_LOAD;
    end
  end

endmodule

// File: rtl/arbitro_memoria.sv
// Arbitrates a datapath port and a loader port onto one single-port memory.
// Optional ARBITRO_PRIO_CORE_EN selects fixed priority for the datapath.
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state;
  logic              win, sel;
  logic              en_q, we_q;
  logic [1:0]        gnt_q, rv_q;
  logic [DATA_W-1:0] c_rdq, l_rdq;

  arbitro_rr u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({l_req, c_req}),
    .upd     (state == ACCESS),
    .upd_idx (sel),
    .win     (win)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sel       <= PORT_CORE;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      gnt_q     <= '0;
      rv_q      <= '0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      c_rdq     <= '0;
      l_rdq     <= '0;
    end else begin
      case (state)
        IDLE: if (c_req || l_req) begin
          sel       <= win;
          en_q      <= 1'b1;
          we_q      <= win ? l_we : c_we;
          mem_addr  <= win ? l_addr : c_addr;
          mem_wdata <= win ? l_wdata : c_wdata;
          gnt_q     <= win ? 2'b10 : 2'b01;
          busy      <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          en_q  <= 1'b0;
          we_q  <= 1'b0;
          gnt_q <= '0;
          if (we_q) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rv_q  <= sel ? 2'b10 : 2'b01;
            state <= RESP;
          end
        end
        RESP: begin
          rv_q  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
          if (sel) l_rdq <= mem_rdata;
          else     c_rdq <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are masked by rst so an aborting reset suppresses the current cycle too.
  assign mem_en   = en_q & rst;
  assign mem_we   = we_q & rst;
  assign c_gnt    = gnt_q[0] & rst;
  assign l_gnt    = gnt_q[1] & rst;
  assign c_rvalid = rv_q[0] & rst;
  assign l_rvalid = rv_q[1] & rst;
  assign c_rdata  = c_rvalid ? mem_rdata : c_rdq;
  assign l_rdata  = l_rvalid ? mem_rdata : l_rdq;

endmodule
